// File: rtl/conv2x2_stream_engine.sv
// 2x2 convolution engine: loads image rows and kernels one beat at a time,
// computes windows as soon as their rows and kernel are present, and streams
// results out with stall on fifo_full.
`timescale 1ns/1ps
module conv2x2_stream_engine #(
    parameter int unsigned IMG_N = 6,
    parameter int unsigned NUM_K = 6,
    parameter int unsigned PIX_W = 3,
    parameter int unsigned KW    = 3,
    parameter int unsigned OUT_W = PIX_W + KW + 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [IMG_N*PIX_W+4*KW-1:0]   in_data,
    input  logic                          stride_mode,
    input  logic                          fifo_full,
    output logic                          out_valid,
    output logic [OUT_W-1:0]              out_data,
    output logic                          busy,
    output logic                          done
);

    localparam int unsigned L     = (IMG_N > NUM_K) ? IMG_N : NUM_K;
    localparam int unsigned CW    = $clog2(L + 1);
    localparam int unsigned RW    = $clog2(IMG_N);
    localparam int unsigned KIW   = (NUM_K > 1) ? $clog2(NUM_K) : 1;
    localparam int unsigned LAST1 = IMG_N - 2;
    localparam int unsigned LAST2 = (IMG_N - 2) / 2;

    typedef enum logic [1:0] {StIdle, StLoadCnn, StDone} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   load_cnt_q, load_cnt_d;
    logic [CW-1:0]   wx_q, wx_d, wy_q, wy_d, k_q, k_d;
    logic            stride_q, stride_d;
    logic            busy_q, busy_d;

    logic [PIX_W-1:0] pix_q [IMG_N][IMG_N];
    logic [4*KW-1:0]  kern_q [NUM_K];

    logic            accept, ready, fire;
    logic [CW-1:0]   beat_idx, last_pos;
    logic [RW-1:0]   r0, r1, c0, c1;
    logic [KIW-1:0]  ki;
    logic [31:0]     rows_needed;
    logic [OUT_W-1:0] sum;

    // Beat acceptance, window addressing, readiness and the MAC result.
    always_comb begin
        accept   = in_valid && ((state_q != StLoadCnn) || (load_cnt_q < CW'(L)));
        // A beat outside a frame is always beat 0 of a new frame.
        beat_idx = (state_q == StLoadCnn) ? load_cnt_q : '0;
        last_pos = stride_q ? CW'(LAST2) : CW'(LAST1);
        r0 = stride_q ? RW'({wy_q, 1'b0}) : RW'(wy_q);
        c0 = stride_q ? RW'({wx_q, 1'b0}) : RW'(wx_q);
        r1 = r0 + RW'(1);
        c1 = c0 + RW'(1);
        ki = KIW'(k_q);
        rows_needed = 32'(stride_q ? {wy_q, 1'b0} : {1'b0, wy_q}) + 32'd2;
        ready = (state_q == StLoadCnn) && (32'(load_cnt_q) >= rows_needed) &&
                (load_cnt_q > k_q);
        fire  = ready && !fifo_full;
        sum = OUT_W'(pix_q[r0][c0]) * OUT_W'(kern_q[ki][0*KW +: KW]) +
              OUT_W'(pix_q[r0][c1]) * OUT_W'(kern_q[ki][1*KW +: KW]) +
              OUT_W'(pix_q[r1][c0]) * OUT_W'(kern_q[ki][2*KW +: KW]) +
              OUT_W'(pix_q[r1][c1]) * OUT_W'(kern_q[ki][3*KW +: KW]);
        out_valid = fire;
        out_data  = fire ? sum : '0;
        busy      = busy_q;
        done      = (state_q == StDone);
    end

    // Frame FSM and window counters (wx fastest, then wy, then k).
    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        wx_d       = wx_q;
        wy_d       = wy_q;
        k_d        = k_q;
        stride_d   = stride_q;
        busy_d     = busy_q;
        unique case (state_q)
            StIdle, StDone: begin
                wx_d = '0;
                wy_d = '0;
                k_d  = '0;
                if (accept) begin
                    state_d    = StLoadCnn;
                    load_cnt_d = CW'(1);
                    stride_d   = stride_mode;
                    busy_d     = 1'b1;
                end else begin
                    state_d    = StIdle;
                    load_cnt_d = '0;
                    busy_d     = 1'b0;
                end
            end
            StLoadCnn: begin
                if (accept) load_cnt_d = load_cnt_q + CW'(1);
                if (fire) begin
                    if (wx_q != last_pos) begin
                        wx_d = wx_q + CW'(1);
                    end else begin
                        wx_d = '0;
                        if (wy_q != last_pos) begin
                            wy_d = wy_q + CW'(1);
                        end else begin
                            wy_d = '0;
                            if (k_q != CW'(NUM_K - 1)) begin
                                k_d = k_q + CW'(1);
                            end else begin
                                k_d     = '0;
                                state_d = StDone;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, counter and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            load_cnt_q <= '0;
            wx_q       <= '0;
            wy_q       <= '0;
            k_q        <= '0;
            stride_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            wx_q       <= wx_d;
            wy_q       <= wy_d;
            k_q        <= k_d;
            stride_q   <= stride_d;
            busy_q     <= busy_d;
        end
    end

    // Row and kernel storage, written by accepted beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < IMG_N; r++) begin
                for (int c = 0; c < IMG_N; c++) pix_q[r][c] <= '0;
            end
            for (int k = 0; k < NUM_K; k++) kern_q[k] <= '0;
        end else if (accept) begin
            if (beat_idx < CW'(IMG_N)) begin
                for (int c = 0; c < IMG_N; c++) begin
                    pix_q[RW'(beat_idx)][c] <= in_data[4*KW + c*PIX_W +: PIX_W];
                end
            end
            if (beat_idx < CW'(NUM_K)) kern_q[KIW'(beat_idx)] <= in_data[4*KW-1:0];
        end
    end

endmodule

// File: tb/tb_conv2x2_stream_engine.sv
// Self-checking bench for conv2x2_stream_engine at default parameters.
`timescale 1ns/1ps
module tb_conv2x2_stream_engine;

    logic        clk, rst_n, in_valid, stride_mode, fifo_full;
    logic [29:0] in_data;
    logic        out_valid, busy, done;
    logic [7:0]  out_data;

    conv2x2_stream_engine dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .stride_mode(stride_mode),
        .fifo_full  (fifo_full),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        int mode;      // 0 zeros, 1 all sevens, 2 ramp pattern
        bit stride;
        int gap;       // idle cycles between beats
        int full_pct;  // fifo_full probability in percent
        int exp_cnt;
        bit chk_lat;
        int chk_idx;
        int chk_val;
    } vec_t;

    int n_cmp = 0, n_fail = 0;
    int cyc = 0, beat0_cyc = 0, first_cyc = -1;
    int done_cnt = 0, viol = 0, full_pct = 0;
    logic [7:0] q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        fifo_full = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            fifo_full = (full_pct > 0) && ($urandom_range(0, 99) < full_pct);
        end
    end

    // Output monitor, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (out_valid) begin
                q.push_back(out_data);
                if (first_cyc < 0) first_cyc = cyc;
                if (fifo_full) viol++;
            end else if (out_data != 8'd0) begin
                viol++;
            end
            if (done) done_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int pixv(int mode, int r, int c);
        if (mode == 0) return 0;
        if (mode == 1) return 7;
        return (r + 2 * c) % 8;
    endfunction

    function automatic int kerv(int mode, int k, int c);
        if (mode == 0) return 0;
        if (mode == 1) return 7;
        return (k + c + 1) % 8;
    endfunction

    function automatic int model(int mode, bit stride, int idx);
        int s, p, k, rem, r, c;
        s = stride ? 2 : 1;
        p = (6 - 2) / s + 1;
        k = idx / (p * p);
        rem = idx % (p * p);
        r = (rem / p) * s;
        c = (rem % p) * s;
        return kerv(mode, k, 0) * pixv(mode, r, c) + kerv(mode, k, 1) * pixv(mode, r, c + 1) +
               kerv(mode, k, 2) * pixv(mode, r + 1, c) +
               kerv(mode, k, 3) * pixv(mode, r + 1, c + 1);
    endfunction

    function automatic logic [29:0] mk_beat(int mode, int i);
        logic [29:0] b;
        b = '0;
        for (int c = 0; c < 4; c++) b[c*3 +: 3] = 3'(kerv(mode, i, c));
        for (int j = 0; j < 6; j++) b[12 + j*3 +: 3] = 3'(pixv(mode, i, j));
        return b;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at #1 after a posedge; stride_mode flips after beat 0 to prove it is ignored.
    task automatic send_beats(input int mode, input bit stride, input int gap);
        for (int i = 0; i < 6; i++) begin
            in_valid    = 1'b1;
            in_data     = mk_beat(mode, i);
            stride_mode = (i == 0) ? stride : ~stride;
            if (i == 0) beat0_cyc = cyc;
            @(posedge clk);
            #1;
            if (gap > 0) begin
                in_valid = 1'b0;
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (done_cnt < target) chk("done_timeout", done_cnt, target);
    endtask

    task automatic chk_seq(input string name, input int mode, input bit stride, input int cnt);
        for (int i = 0; i < cnt && i < q.size(); i++) begin
            chk($sformatf("%s_res%0d", name, i), int'(q[i]), model(mode, stride, i));
        end
    endtask

    task automatic run_frame(input vec_t v, input int vi);
        string nm;
        nm = $sformatf("v%0d", vi);
        q.delete();
        done_cnt  = 0;
        viol      = 0;
        first_cyc = -1;
        full_pct  = v.full_pct;
        @(posedge clk);
        #1;
        send_beats(v.mode, v.stride, v.gap);
        wait_done(1);
        full_pct = 0;
        repeat (3) @(posedge clk);
        #1;
        chk({nm, "_count"}, q.size(), v.exp_cnt);
        chk({nm, "_done_pulses"}, done_cnt, 1);
        chk({nm, "_busy_after"}, int'(busy), 0);
        chk({nm, "_protocol_viol"}, viol, 0);
        if (v.chk_lat) chk({nm, "_latency"}, first_cyc - beat0_cyc, 2);
        if (v.chk_idx < q.size()) chk({nm, "_hand_value"}, int'(q[v.chk_idx]), v.chk_val);
        chk_seq(nm, v.mode, v.stride, v.exp_cnt);
    endtask

    vec_t vecs[7];
    int   n;

    initial begin
        vecs[0] = '{mode: 2, stride: 0, gap: 0,  full_pct: 0,  exp_cnt: 150, chk_lat: 1,
                    chk_idx: 149, chk_val: 73};
        vecs[1] = '{mode: 1, stride: 0, gap: 0,  full_pct: 0,  exp_cnt: 150, chk_lat: 1,
                    chk_idx: 77,  chk_val: 196};
        vecs[2] = '{mode: 0, stride: 0, gap: 0,  full_pct: 0,  exp_cnt: 150, chk_lat: 1,
                    chk_idx: 10,  chk_val: 0};
        vecs[3] = '{mode: 2, stride: 0, gap: 0,  full_pct: 50, exp_cnt: 150, chk_lat: 0,
                    chk_idx: 0,   chk_val: 19};
        vecs[4] = '{mode: 2, stride: 1, gap: 0,  full_pct: 0,  exp_cnt: 54,  chk_lat: 1,
                    chk_idx: 5,   chk_val: 39};
        vecs[5] = '{mode: 2, stride: 0, gap: 10, full_pct: 0,  exp_cnt: 150, chk_lat: 0,
                    chk_idx: 149, chk_val: 73};
        vecs[6] = '{mode: 2, stride: 1, gap: 10, full_pct: 30, exp_cnt: 54,  chk_lat: 0,
                    chk_idx: 53,  chk_val: 73};

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        stride_mode = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_frame(vecs[i], i);

        // Reset mid-frame at result 40, then a fresh frame.
        q.delete();
        done_cnt = 0;
        @(posedge clk);
        #1;
        send_beats(2, 0, 0);
        n = 0;
        while (q.size() < 40 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("abort_reached40", int'(q.size() >= 40), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_out_data", int'(out_data), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_no_done", done_cnt, 0);
        run_frame(vecs[0], 7);

        // Back-to-back frames: second frame's beat 0 lands in the DONE cycle.
        q.delete();
        done_cnt = 0;
        @(posedge clk);
        #1;
        send_beats(2, 0, 0);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 3000);
        chk("b2b_done_seen", int'(done), 1);
        chk("b2b_busy_in_done", int'(busy), 0);
        chk("b2b_first_count", q.size(), 150);
        q.delete();
        first_cyc = -1;
        viol      = 0;
        send_beats(1, 0, 0);
        wait_done(2);
        repeat (2) @(posedge clk);
        #1;
        chk("b2b_count", q.size(), 150);
        chk("b2b_done_pulses", done_cnt, 2);
        chk("b2b_latency", first_cyc - beat0_cyc, 2);
        chk("b2b_viol", viol, 0);
        chk_seq("b2b", 1, 0, 150);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/conv2x2_stream_engine.md
# conv2x2_stream_engine

Parametrised 2x2 convolution engine for the clk2 domain. It receives image rows and kernels one beat at a time from the handshake synchroniser and starts computing as soon as the rows a window needs have arrived. Results stream into the clk2→clk1 async FIFO, with stall on `fifo_full`. It generalises the fixed 6x6 / six-kernel engine: image size, kernel count, pixel and coefficient widths are parameters, and it adds a stride-2 mode and a frame-done pulse.

## Interface
- `IMG_N`, 6: image is `IMG_N`x`IMG_N` pixels (legal range 2..16).
- `NUM_K`, 6: number of 2x2 kernels per frame (legal range 1..16).
- `PIX_W`, 3: unsigned pixel width.
- `KW`, 3: unsigned kernel coefficient width.
- `OUT_W`, `PIX_W+KW+2`: result width; exact, no overflow possible.
- `clk` input 1: single clock. Reset is asynchronous and active-low.
- `rst_n` input 1: asynchronous active-low reset.
- `in_valid` input 1: one load beat this cycle.
- `in_data` input `IMG_N*PIX_W+4*KW`: beat i carries the following fields:
  - `[4*KW-1:0]`: kernel i, with coefficient c at `[c*KW +: KW]`, c0=(y,x), c1=(y,x+1), c2=(y+1,x), c3=(y+1,x+1).
  - `[4*KW + j*PIX_W +: PIX_W]`: pixel (row i, column j).
- `stride_mode` input 1: 0 = stride 1, 1 = stride 2. Sampled on the first beat of a frame.
- `fifo_full` input 1: FIFO cannot accept a write this cycle.
- `out_valid` output 1: FIFO write strobe; one result per asserted cycle.
- `out_data` output `OUT_W`: result; 0 when `out_valid`=0.
- `busy` output 1: frame in progress.
- `done` output 1: one-cycle pulse after the last result of a frame.

## Operation
- Definitions:
  - L = max(`IMG_N`, `NUM_K`) beats per frame.
  - S = 1 or 2 (stride).
  - P = floor((`IMG_N`-2)/S)+1 window positions per axis.
  - Frame total = `NUM_K`·P·P results.
- Beat accounting:
  - A beat is accepted when `in_valid`=1 and (`busy`=0 or load count < L).
  - Beat i stores row i if i < `IMG_N` and kernel i if i < `NUM_K`.
  - Beats after the L-th, while `busy`=1, are ignored.
- States:
  - IDLE: `busy`=0, all counters cleared. An accepted beat moves to LOAD_CNN, latches `stride_mode`, and sets rows_loaded and kernels_loaded from that beat.
  - LOAD_CNN: window (k, wy, wx) is computed on the image at rows wy·S, wy·S+1 and columns wx·S, wx·S+1. It is ready when rows_loaded ≥ wy·S+2 and kernels_loaded > k.
    - If ready and `fifo_full`=0: `out_valid`=1 and the counters advance with wx fastest, then wy, then k.
    - Otherwise (not ready or `fifo_full`=1): hold, `out_valid`=0.
  - After the last window is written, go to DONE.
  - DONE: `done`=1 and `busy`=0 for one cycle, then IDLE. A beat accepted in DONE starts the next frame, exactly as a beat accepted in IDLE does.
- `out_valid` and `out_data` are combinational from the registered state, counters and `fifo_full`. `out_data` = Σ pixel·coefficient over the four taps, unsigned, zero-extended to `OUT_W`.
- `busy` is registered. It is high from the cycle after the first accepted beat through the cycle of the last result write.
- Loading and computing overlap. Beats may arrive with arbitrary gaps; computation stalls only on missing rows or kernels.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `busy`=0, `done`=0; state IDLE; all row, kernel and counter storage zero.
- Reset mid-frame aborts the frame. No `done` is produced, and the first beat after release is beat 0.
- First-result latency: with beats 0 and 1 accepted at cycles t and t+1 and `fifo_full`=0, `out_valid` is first high at t+2.
- Steady throughput: 1 result/cycle while data is ready and `fifo_full`=0.
- `fifo_full` asserted in cycle c means no write in cycle c and no counter change. Writes resume in the first cycle `fifo_full`=0.
- `done` is high the cycle after the final write.
- `stride_mode` changes mid-frame have no effect.

## Test plan
- Default parameters, stride 1, 6 back-to-back beats, `fifo_full`=0:
  - Exactly 150 results in order k→wy→wx, matching the golden model.
  - First `out_valid` 2 cycles after beat 0.
  - `done` is a single pulse and `busy` then low.
- All pixels 7, all coefficients 7 → every result 196. All zeros → 150 results of 0.
- `fifo_full` random at 50% → still exactly 150 results with no duplicates or drops, and `out_valid` never high while `fifo_full`=1.
- `stride_mode`=1, `IMG_N`=6 → 6·3·3 = 54 results; window (0,1,2) uses rows 2–3 and columns 4–5.
- Beats gapped by 10 idle cycles → computation stalls at each row boundary (wy needs rows wy+1 present), and the final result sequence is identical to the no-gap case.
- Reset asserted at result 40, followed by a fresh frame → all outputs 0 during reset, and the new frame yields the full 150 correct results. A second frame started in the DONE cycle also yields 150.
